// File: rtl/matrix_scanner_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
// Holds the FSM state encoding and the column-priority helper.
package matrix_scanner_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  localparam int MAX_COLS = 32;

  // Index of the lowest low (pressed) column among the first n bits; 0 if none.
  function automatic int lowest_low_col(input logic [MAX_COLS-1:0] v, input int n);
    int idx;
    idx = 0;
    for (int i = MAX_COLS - 1; i >= 0; i--) begin
      if (i < n && !v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/matrix_scanner_if.sv
// Keypad-side and decoder-side signals of the matrix scanner.
// The scanner uses the master view; keypad model / consumer use the slave view.
interface matrix_scanner_if #(
  parameter int NROWS = 4,
  parameter int NCOLS = 4
);
  localparam int KW = $clog2(NROWS * NCOLS);

  logic [NCOLS-1:0] cols;
  logic [NROWS-1:0] rows;
  logic [KW-1:0]    key_code;
  logic             key_valid;
  logic             key_held;

  modport master (
    input  cols,
    output rows, key_code, key_valid, key_held
  );

  modport slave (
    output cols,
    input  rows, key_code, key_valid, key_held
  );

endinterface

// File: rtl/matrix_scanner_sync2.sv
// Two-flop synchronizer for asynchronous inputs, parametrised width.
// Resets to all-ones so an active-low bus reads as idle out of reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: flops use non-blocking assignments so meta->q forms a real two-stage pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/matrix_scanner.sv
// Keypad matrix scanner: row strobing, debounce, single-key lockout and
// optional auto-repeat, producing a linear key code with a one-cycle strobe.
module matrix_scanner
  import matrix_scanner_pkg::*;
#(
  parameter int NROWS           = 4,
  parameter int NCOLS           = 4,
  parameter int SCAN_DIV        = 2400,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic              clk,
  input  logic              reset,
  matrix_scanner_if.master  bus
);

  localparam int KW  = $clog2(NROWS * NCOLS);
  localparam int RW  = $clog2(NROWS);
  localparam int CLW = $clog2(NCOLS);
  localparam int CW  = $clog2(max3(SCAN_DIV, DEBOUNCE_CYCLES, REPEAT_CYCLES));

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [RW-1:0] ROW_LAST  = RW'(NROWS - 1);

  logic [NCOLS-1:0] cs;

  state_t          state, state_d;
  logic [RW-1:0]   row, row_d, row_inc;
  logic [CLW-1:0]  col, col_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [CW-1:0]   rep, rep_d;
  logic [KW-1:0]   key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            col_low;

  sync2 #(.W(NCOLS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.cols),
    .q     (cs)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SCAN;
      row         <= '0;
      col         <= '0;
      cnt         <= '0;
      rep         <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state       <= state_d;
      row         <= row_d;
      col         <= col_d;
      cnt         <= cnt_d;
      rep         <= rep_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign col_low = ~cs[col];
  assign row_inc = (row == ROW_LAST) ? '0 : row + 1'b1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state;
    row_d       = row;
    col_d       = col;
    cnt_d       = cnt;
    rep_d       = rep;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;

    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_d = '0;
          if (&cs) begin
            row_d = row_inc;
          end else begin
            col_d   = CLW'(lowest_low_col(MAX_COLS'(cs), NCOLS));
            state_d = DEBOUNCE;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (!col_low) begin
          state_d = SCAN;
          row_d   = row_inc;
          cnt_d   = '0;
        end else if (cnt == DB_LAST) begin
          state_d     = HELD;
          cnt_d       = '0;
          rep_d       = '0;
          key_code_d  = KW'(int'(row) * NCOLS + int'(col));
          key_valid_d = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      HELD: begin
        // Only the captured column is watched; other keys are locked out.
        if (!col_low) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else if (REPEAT_CYCLES > 0) begin
          if (rep == REP_LAST) begin
            rep_d       = '0;
            key_valid_d = ~key_valid_q;
          end else begin
            rep_d = rep + 1'b1;
          end
        end
      end

      RELEASE: begin
        // A returning low is contact bounce: resume holding, repeat phase intact.
        if (col_low) begin
          state_d = HELD;
        end else if (cnt == DB_LAST) begin
          state_d = SCAN;
          row_d   = row_inc;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  assign bus.rows      = NROWS'(1) << row;
  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_held  = (state == HELD) || (state == RELEASE);

endmodule

// File: tb/tb_matrix_scanner.sv
// Self-checking bench for matrix_scanner: directed keypad scenarios with a
// scoreboard of expected key codes checked by per-DUT monitors.
module tb_matrix_scanner;

  logic clk;
  logic reset;

  matrix_scanner_if #(.NROWS(4), .NCOLS(4)) bus ();
  matrix_scanner_if #(.NROWS(4), .NCOLS(4)) bus_rep ();

  matrix_scanner #(
    .NROWS(4), .NCOLS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8), .REPEAT_CYCLES(0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  matrix_scanner #(
    .NROWS(4), .NCOLS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8), .REPEAT_CYCLES(32)
  ) dut_rep (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_rep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad models: a pressed key pulls its column low while its row is strobed.
  logic [3:0][3:0] press;
  logic [3:0][3:0] press_rep;

  always_comb begin
    bus.cols = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r][c] && bus.rows[r]) bus.cols[c] = 1'b0;
  end

  always_comb begin
    bus_rep.cols = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press_rep[r][c] && bus_rep.rows[r]) bus_rep.cols[c] = 1'b0;
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] exp_rep_q[$];
  logic [3:0] exp_main_v;
  logic [3:0] exp_rep_v;
  logic       prev_main = 1'b0;
  logic       prev_rep  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_held(input bit on_rep, input logic val, input int budget, input string name);
    int n = 0;
    while (((on_rep ? bus_rep.key_held : bus.key_held) !== val) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(on_rep ? bus_rep.key_held : bus.key_held), 32'(val));
  endtask

  // Monitors: every key_valid pulse must match the next queued key code.
  always @(negedge clk) begin
    if (bus.key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL main_pulse: unexpected key_valid with key_code=%0d, none expected (t=%0t)",
                 bus.key_code, $time);
      end else begin
        exp_main_v = exp_q.pop_front();
        check("main_key_code", 32'(bus.key_code), 32'(exp_main_v));
      end
      check("main_valid_gap", 32'(prev_main), 32'(0));
    end
    prev_main = bus.key_valid;
  end

  always @(negedge clk) begin
    if (bus_rep.key_valid === 1'b1) begin
      if (exp_rep_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rep_pulse: unexpected key_valid with key_code=%0d, none expected (t=%0t)",
                 bus_rep.key_code, $time);
      end else begin
        exp_rep_v = exp_rep_q.pop_front();
        check("rep_key_code", 32'(bus_rep.key_code), 32'(exp_rep_v));
      end
      check("rep_valid_gap", 32'(prev_rep), 32'(0));
    end
    prev_rep = bus_rep.key_valid;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    press     = '0;
    press_rep = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("reset_rows",      32'(bus.rows),      32'(1));
    check("reset_key_code",  32'(bus.key_code),  32'(0));
    check("reset_key_valid", 32'(bus.key_valid), 32'(0));
    check("reset_key_held",  32'(bus.key_held),  32'(0));

    // Idle scan: each row strobed for 4 cycles in turn
    reset = 1'b1;
    for (int i = 0; i < 64; i++) begin
      check("idle_rows", 32'(bus.rows), 32'(1) << ((i / 4) % 4));
      @(negedge clk);
    end

    // Clean press of row 2 / col 1 -> code 9
    exp_q.push_back(4'd9);
    press[2][1] = 1'b1;
    wait_held(1'b0, 1'b1, 100, "press_held_rise");
    check("press_code", 32'(bus.key_code), 32'(9));
    for (int i = 0; i < 20; i++) begin
      check("press_rows_frozen", 32'(bus.rows), 32'(4'b0100));
      @(negedge clk);
    end
    press[2][1] = 1'b0;
    repeat (10) @(negedge clk);
    check("release_held_10", 32'(bus.key_held), 32'(1));
    @(negedge clk);
    check("release_held_11", 32'(bus.key_held), 32'(0));
    check("release_resume_row", 32'(bus.rows), 32'(4'b1000));

    // Bouncing press of row 1 / col 3 -> code 7, bouncing release
    exp_q.push_back(4'd7);
    for (int k = 0; k < 40; k++) begin
      press[1][3] = ((k / 3) % 2 == 0);
      @(negedge clk);
    end
    press[1][3] = 1'b1;
    wait_held(1'b0, 1'b1, 200, "bounce_held_rise");
    check("bounce_code", 32'(bus.key_code), 32'(7));
    for (int g = 0; g < 4; g++) begin
      press[1][3] = 1'b0;
      repeat (3) @(negedge clk);
      press[1][3] = 1'b1;
      repeat (3) @(negedge clk);
      check("bounce_release_glitch_held", 32'(bus.key_held), 32'(1));
    end
    press[1][3] = 1'b0;
    wait_held(1'b0, 1'b0, 40, "bounce_held_fall");
    check("bounce_resume_row", 32'(bus.rows), 32'(4'b0100));

    // Lockout: col 2 on row 0 accepted, later col 0 ignored
    exp_q.push_back(4'd2);
    press[0][2] = 1'b1;
    wait_held(1'b0, 1'b1, 100, "lockout_held_rise");
    press[0][0] = 1'b1;
    repeat (30) @(negedge clk);
    check("lockout_held",     32'(bus.key_held), 32'(1));
    check("lockout_code",     32'(bus.key_code), 32'(2));
    check("lockout_rows",     32'(bus.rows),     32'(4'b0001));
    press[0] = '0;
    wait_held(1'b0, 1'b0, 40, "lockout_held_fall");

    // Tie: cols 0 and 2 on row 0 together -> lowest index wins
    exp_q.push_back(4'd0);
    press[0][0] = 1'b1;
    press[0][2] = 1'b1;
    wait_held(1'b0, 1'b1, 100, "tie_held_rise");
    check("tie_code", 32'(bus.key_code), 32'(0));
    press[0] = '0;
    wait_held(1'b0, 1'b0, 40, "tie_held_fall");

    // Reset mid-hold of row 3 / col 2 -> code 14, re-detected afterwards
    exp_q.push_back(4'd14);
    press[3][2] = 1'b1;
    wait_held(1'b0, 1'b1, 100, "rst_held_rise");
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_async_held",  32'(bus.key_held),  32'(0));
    check("rst_async_valid", 32'(bus.key_valid), 32'(0));
    check("rst_async_code",  32'(bus.key_code),  32'(0));
    check("rst_async_rows",  32'(bus.rows),      32'(1));
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(4'd14);
    reset = 1'b1;
    wait_held(1'b0, 1'b1, 100, "rst_redetect_held");
    check("rst_redetect_code", 32'(bus.key_code), 32'(14));
    press[3][2] = 1'b0;
    wait_held(1'b0, 1'b0, 40, "rst_held_fall");

    // Auto-repeat on the second instance: key 5 (row 1 / col 1), 32-cycle period
    for (int i = 0; i < 6; i++) exp_rep_q.push_back(4'd5);
    press_rep[1][1] = 1'b1;
    wait_held(1'b1, 1'b1, 100, "rep_held_rise");
    for (int k = 0; k <= 170; k++) begin
      check("rep_pulse_timing", 32'(bus_rep.key_valid), 32'(k % 32 == 0));
      @(negedge clk);
    end
    press_rep[1][1] = 1'b0;
    wait_held(1'b1, 1'b0, 40, "rep_held_fall");
    repeat (60) @(negedge clk);

    check("main_queue_empty", 32'(exp_q.size()),     32'(0));
    check("rep_queue_empty",  32'(exp_rep_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/matrix_scanner.md
# matrix_scanner

Parametrised keypad matrix scanner with integrated debounce, single-key lockout and optional auto-repeat. It drives one-hot row strobes, samples active-low column inputs and emits a linear key code with a one-cycle valid strobe. It sits between the keypad pins and the display/decode logic, replacing the separate scanner, debouncer and decode arrangement with one self-contained block.

## Interface
- NROWS, 4, number of row strobes (≥2)
- NCOLS, 4, number of column inputs (≥2)
- SCAN_DIV, 2400, clk cycles each row is driven while scanning (≥2)
- DEBOUNCE_CYCLES, 20, consecutive stable cycles required for press and for release (≥2)
- REPEAT_CYCLES, 0, auto-repeat period in cycles while held; 0 disables repeat
- KW, $clog2(NROWS*NCOLS), key code width (derived localparam)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cols  in  NCOLS  raw column inputs, active-low, asynchronous to clk
- rows  out  NROWS  one-hot, active-high row strobe
- key_code  out  KW  row*NCOLS + col of the last accepted key
- key_valid  out  1  one-cycle pulse on accepted press and on each repeat
- key_held  out  1  high while the accepted key is held (HELD or RELEASE state)

## Operation
- cols pass through a 2-flop synchronizer; all logic uses the synchronized value `cs`.
- Reset values: state SCAN, row index 0, rows = 1 (row 0), key_code 0, key_valid 0, key_held 0, all counters 0.
- States:
  - SCAN: drive row r. Dwell counter runs 0..SCAN_DIV-1. On the last dwell cycle, if cs == all-ones, advance r (NROWS-1 wraps to 0). Otherwise capture r and c, the lowest-index low column, then go to DEBOUNCE. Multiple low columns: lowest index wins.
  - DEBOUNCE: row frozen. Each cycle with cs[c]==0, increment the counter. When it reaches DEBOUNCE_CYCLES-1, go to HELD, load key_code and pulse key_valid. If cs[c]==1, return to SCAN at row r+1 (wrapped) with no output.
  - HELD: key_held=1, row frozen, other columns ignored (lockout). cs[c]==1 goes to RELEASE. If REPEAT_CYCLES>0, a repeat counter pulses key_valid every REPEAT_CYCLES held cycles; it is cleared on entry to HELD.
  - RELEASE: count consecutive cs[c]==1 cycles. At DEBOUNCE_CYCLES-1, go to SCAN at row r+1 with key_held=0. If cs[c]==0 first, return to HELD with no new pulse and the repeat counter preserved.
- key_code holds its value until the next accepted press.
- Counter widths are sized to the largest of SCAN_DIV, DEBOUNCE_CYCLES and REPEAT_CYCLES. No counter wraps unguarded.

## Timing
- Synchronizer latency: 2 cycles from a cols pin to cs.
- A press stable from the start of the row dwell is captured at the end of that dwell. key_valid asserts DEBOUNCE_CYCLES cycles after entry to DEBOUNCE and is registered.
- key_valid is never high for two consecutive cycles.
- Release is detected DEBOUNCE_CYCLES cycles after cs[c] goes high. Scanning resumes on the next cycle.
- Asynchronous reset mid-press clears outputs immediately. After reset deassertion the key is re-detected from SCAN row 0 as a new press.
- rows changes only on state/row transitions. It is never all-zero and never multi-hot.

## Structure
- Package matrix_scanner_pkg: state enum typedef (SCAN, DEBOUNCE, HELD, RELEASE) and a helper function for the lowest-low-column index.
- Sub-module sync2: a parametrised-width 2-flop synchronizer, reset to all-ones.
- The remainder is a single FSM with row, dwell, debounce and repeat counters in matrix_scanner.

## Test plan
Bench parameters: NROWS=4, NCOLS=4, SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=0 unless stated.

- Idle: cols=4'b1111 for 64 cycles → rows cycles 0001→0010→0100→1000, 4 cycles each; key_valid never asserts.
- Clean press: hold row 2 / col 1 low → exactly one key_valid pulse with key_code=9; key_held=1 until 8 cycles after release; rows frozen at 0100 meanwhile.
- Bounce: toggle row 1 / col 3 every 3 cycles for 40 cycles, then hold low → one pulse, key_code=7. Release bounce with 3-cycle glitches produces no extra pulse.
- Lockout/tie: press col 2 then add col 0 on the same row 0 → key_code=2 only. Simultaneous col 0+2 from idle → key_code=0.
- Repeat: REPEAT_CYCLES=32, hold key 5 for 200 cycles → initial pulse plus 5 repeat pulses spaced 32 cycles; none after release.
- Reset mid-hold: assert reset while key_held=1 → outputs cleared asynchronously. After deassertion with the key still held → new pulse with key_code restored.
